core_meas_router: RTL and testbench
===================================

// Module: core_meas_router
// PURPOSE
//  Per-core function-processor response manager for the distributed processor.
//  Each core issues a fproc request with an ID selecting a measurement channel or the LUT.
//  The block waits for that source and returns a registered one-cycle ready pulse with the result.
//  Adds generalised channel select, timeout with error flag, invalid-ID error and registered outputs.
// PARAMETERS
//  N_CORES       5        number of cores / fproc ports
//  N_MEAS        N_CORES  number of measurement channels
//  ID_W          8        width of core_id
//  DATA_W        32       width of core_data; result in bit 0, upper bits zero
//  TIMEOUT_CYC   1024     max wait cycles before error completion; 0 = never time out
// PORTS
//  clk          in   1               system clock
//  reset        in   1               asynchronous, active-high reset
//  meas         in   N_MEAS          measurement bit per channel
//  meas_valid   in   N_MEAS          1-cycle strobe: meas[c] valid
//  lut_out      in   N_CORES         LUT result per core
//  lut_ready    in   1               1-cycle strobe: lut_out valid
//  core_enable  in   N_CORES         request strobe per core
//  core_id      in   N_CORES*ID_W    source select, core i at [i*ID_W +: ID_W]
//  core_ready   out  N_CORES         1-cycle completion pulse
//  core_data    out  N_CORES*DATA_W  result, core i at [i*DATA_W +: DATA_W]
//  core_err     out  N_CORES         qualifies core_ready: timeout or bad ID
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-high on port reset.
//    Reset forces all cores to IDLE, all outputs to 0, counters to 0, sticky bits to 0.
//  - Reset mid-request drops the request silently; no ready pulse.
//  - Per-core FSM, independent per core: IDLE, WAIT_MEAS, WAIT_LUT, RESP.
//  - IDLE: core_enable[i]=1 latches id:
//      id <  N_MEAS      -> WAIT_MEAS, channel = id
//      id == all-ones    -> WAIT_LUT
//      otherwise         -> RESP with data=0, err=1
//  - WAIT_MEAS: meas_valid[ch]=1 -> RESP, data[0]=meas[ch], err=0.
//  - WAIT_LUT: lut_ready=1 -> RESP, data[0]=lut_out[i], err=0.
//  - RESP lasts one cycle and asserts core_ready[i] with data/err; next state is IDLE.
//    Latency from source strobe to core_ready = 1 cycle.
//  - Source strobe in the same cycle as an accepted enable is captured.
//    The core enters RESP directly, so ready follows enable by 1 cycle.
//  - core_enable while not IDLE is ignored; no queuing.
//  - core_data/core_err are 0 whenever core_ready=0.
//  - Timeout (TIMEOUT_CYC>0): per-core counter cleared on entering WAIT_*.
//    It increments each wait cycle. When it equals TIMEOUT_CYC-1 with no strobe:
//    RESP, data=0, err=1. A strobe on the final cycle wins over the timeout.
//  - Multiple cores waiting on the same channel all complete on the same strobe.
//  - Counter width is $clog2(TIMEOUT_CYC+1), with a minimum of 1.
// CONFIGURATION
//  - CORE_MEAS_STICKY_EN defined: per-(core,channel) sticky bit set by meas_valid while the core is IDLE.
//    The stored meas value is kept per channel (last written).
//    A later request on that channel completes next cycle using the stored value and clears the sticky bit.
//    A sticky bit set again overwrites the stored value.
//  - Undefined: meas_valid while IDLE is discarded. The request waits for the next strobe.
// TESTING
//  - Core 0 id=0; meas_valid[0]=1, meas[0]=1 three cycles later -> core_ready[0] next cycle, data=1, err=0.
//  - Core 2 id=8'hFF; lut_ready with lut_out[2]=1 -> core_ready[2] next cycle, data=1.
//  - Core 1 id=7 with N_MEAS=5 -> ready 1 cycle after enable, data=0, err=1.
//  - TIMEOUT_CYC=16, no strobe -> ready at wait cycle 16, err=1.
//    Repeat with strobe on cycle 16 -> err=0.
//  - Cores 0,3 both id=2; single meas_valid[2] -> both ready in the same cycle with the same data.
//  - reset pulsed while WAIT_MEAS -> no ready, outputs 0. With STICKY_EN: pre-request strobe serviced next cycle.

Source files
------------

// File: rtl/core_meas_router_if.sv
// Bundles the measurement/LUT sources and the per-core fproc request/response lines.
// The router takes the slave side; the environment or a core cluster drives the master side.
interface core_meas_router_if #(
    parameter int N_CORES = 5,
    parameter int N_MEAS  = N_CORES,
    parameter int ID_W    = 8,
    parameter int DATA_W  = 32
);
    logic [N_MEAS-1:0]         meas;
    logic [N_MEAS-1:0]         meas_valid;
    logic [N_CORES-1:0]        lut_out;
    logic                      lut_ready;
    logic [N_CORES-1:0]        core_enable;
    logic [N_CORES*ID_W-1:0]   core_id;
    logic [N_CORES-1:0]        core_ready;
    logic [N_CORES*DATA_W-1:0] core_data;
    logic [N_CORES-1:0]        core_err;

    modport master (
        output meas, meas_valid, lut_out, lut_ready, core_enable, core_id,
        input  core_ready, core_data, core_err
    );

    modport slave (
        input  meas, meas_valid, lut_out, lut_ready, core_enable, core_id,
        output core_ready, core_data, core_err
    );
endinterface

// File: rtl/core_meas_router.sv
// Per-core fproc response manager: waits on a measurement channel or the LUT and returns a
// registered one-cycle ready pulse. Define CORE_MEAS_STICKY_EN to keep strobes seen while idle.
module core_meas_router #(
    parameter int N_CORES     = 5,
    parameter int N_MEAS      = N_CORES,
    parameter int ID_W        = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    core_meas_router_if.slave bus_if
);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int CH_W  = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
    localparam int CH_N  = 2 ** CH_W;
    localparam bit TMO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ID_W:0]    MEAS_LIM = (ID_W + 1)'(N_MEAS);

    typedef enum logic [1:0] {IDLE, WAIT_MEAS, WAIT_LUT, RESP} state_e;

    // Channel vectors padded to a power of two so any CH_W-bit index stays in range.
    logic [CH_N-1:0] mv_pad, m_pad;
    assign mv_pad = CH_N'(bus_if.meas_valid);
    assign m_pad  = CH_N'(bus_if.meas);

`ifdef CORE_MEAS_STICKY_EN
    logic [N_MEAS-1:0] store_q;
    logic [CH_N-1:0]   st_pad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) store_q <= '0;
        else       store_q <= (store_q & ~bus_if.meas_valid) | (bus_if.meas & bus_if.meas_valid);
    end
    assign st_pad = CH_N'(store_q);
`endif

    logic [N_CORES-1:0]             rdy_all, err_all;
    logic [N_CORES-1:0][DATA_W-1:0] data_all;

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        state_e           state_q, state_d;
        logic [CH_W-1:0]  ch_q, ch_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rdy_q, rdy_d, res_q, res_d, err_q, err_d;
        logic [ID_W-1:0]  id;
        logic [CH_W-1:0]  id_ch;
        logic             id_meas, id_lut, tmo, stk_hit, stk_val;

        assign id      = bus_if.core_id[i*ID_W +: ID_W];
        assign id_ch   = id[CH_W-1:0];
        assign id_meas = ({1'b0, id} < MEAS_LIM);
        assign id_lut  = &id;
        assign tmo     = TMO_EN && (cnt_q == TMO_LAST);

`ifdef CORE_MEAS_STICKY_EN
        logic [N_MEAS-1:0] stk_q, stk_d;
        logic [CH_N-1:0]   stk_pad, clr;

        assign stk_pad = CH_N'(stk_q);
        assign stk_hit = stk_pad[id_ch];
        assign stk_val = st_pad[id_ch];
        assign clr     = CH_N'(1) << id_ch;

        // An accepted request on a channel consumes its sticky bit, live strobe or not.
        always_comb begin
            stk_d = stk_q;
            if (state_q == IDLE) begin
                stk_d = stk_q | bus_if.meas_valid;
                if (bus_if.core_enable[i] && id_meas) stk_d = stk_d & ~N_MEAS'(clr);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) stk_q <= '0;
            else       stk_q <= stk_d;
        end
`else
        assign stk_hit = 1'b0;
        assign stk_val = 1'b0;
`endif

        always_comb begin
            state_d = state_q;
            ch_d    = ch_q;
            cnt_d   = cnt_q;
            rdy_d   = 1'b0;
            res_d   = 1'b0;
            err_d   = 1'b0;
            unique case (state_q)
                IDLE: if (bus_if.core_enable[i]) begin
                    cnt_d = '0;
                    if (id_meas) begin
                        ch_d = id_ch;
                        if (mv_pad[id_ch]) begin
                            state_d = RESP; rdy_d = 1'b1; res_d = m_pad[id_ch];
                        end else if (stk_hit) begin
                            state_d = RESP; rdy_d = 1'b1; res_d = stk_val;
                        end else begin
                            state_d = WAIT_MEAS;
                        end
                    end else if (id_lut) begin
                        if (bus_if.lut_ready) begin
                            state_d = RESP; rdy_d = 1'b1; res_d = bus_if.lut_out[i];
                        end else begin
                            state_d = WAIT_LUT;
                        end
                    end else begin
                        state_d = RESP; rdy_d = 1'b1; err_d = 1'b1;
                    end
                end
                // A strobe on the last allowed wait cycle takes precedence over the timeout.
                WAIT_MEAS: begin
                    if (mv_pad[ch_q]) begin
                        state_d = RESP; rdy_d = 1'b1; res_d = m_pad[ch_q];
                    end else if (tmo) begin
                        state_d = RESP; rdy_d = 1'b1; err_d = 1'b1;
                    end else if (TMO_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LUT: begin
                    if (bus_if.lut_ready) begin
                        state_d = RESP; rdy_d = 1'b1; res_d = bus_if.lut_out[i];
                    end else if (tmo) begin
                        state_d = RESP; rdy_d = 1'b1; err_d = 1'b1;
                    end else if (TMO_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                ch_q    <= '0;
                cnt_q   <= '0;
                rdy_q   <= 1'b0;
                res_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ch_q    <= ch_d;
                cnt_q   <= cnt_d;
                rdy_q   <= rdy_d;
                res_q   <= res_d;
                err_q   <= err_d;
            end
        end

        assign rdy_all[i]  = rdy_q;
        assign err_all[i]  = err_q;
        assign data_all[i] = {{(DATA_W-1){1'b0}}, res_q};
    end

    assign bus_if.core_ready = rdy_all;
    assign bus_if.core_err   = err_all;
    assign bus_if.core_data  = data_all;
endmodule

// File: tb/tb_core_meas_router.sv
// Directed bench for core_meas_router with TIMEOUT_CYC=16 and five cores/channels.
module tb_core_meas_router;
    localparam int NC  = 5;
    localparam int IDW = 8;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    core_meas_router_if #(.N_CORES(NC), .N_MEAS(NC), .ID_W(IDW), .DATA_W(DW)) bus ();

    core_meas_router #(
        .N_CORES(NC), .N_MEAS(NC), .ID_W(IDW), .DATA_W(DW), .TIMEOUT_CYC(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int c);
        return bus.core_data[c*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int c, input logic [IDW-1:0] id);
        bus.core_enable[c]         = 1'b1;
        bus.core_id[c*IDW +: IDW]  = id;
    endtask

    task automatic quiet();
        bus.core_enable = '0;
        bus.meas_valid  = '0;
        bus.lut_ready   = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.meas        = '0;
        bus.meas_valid  = '0;
        bus.lut_out     = '0;
        bus.lut_ready   = 1'b0;
        bus.core_enable = '0;
        bus.core_id     = '0;
        #12;
        chk("rst_ready", 32'(bus.core_ready), 0);
        chk("rst_err",   32'(bus.core_err), 0);
        chk("rst_data",  32'(|bus.core_data), 0);
        reset = 1'b0;

        // Core 0 waits on channel 0; strobe three cycles after the request.
        req(0, 8'h00); tick(); quiet();
        chk("meas_wait", 32'(bus.core_ready), 0);
        tick(); tick();
        bus.meas_valid = 5'b00001; bus.meas = 5'b00001;
        tick(); quiet();
        chk("meas_ready", 32'(bus.core_ready), 32'h01);
        chk("meas_data",  dat(0), 1);
        chk("meas_err",   32'(bus.core_err), 0);
        tick();
        chk("meas_pulse", 32'(bus.core_ready), 0);
        chk("meas_data0", dat(0), 0);

        // Core 2 waits on the LUT.
        req(2, 8'hFF); tick(); quiet();
        chk("lut_wait", 32'(bus.core_ready), 0);
        bus.lut_ready = 1'b1; bus.lut_out = 5'b00100;
        tick(); quiet();
        chk("lut_ready", 32'(bus.core_ready), 32'h04);
        chk("lut_data",  dat(2), 1);
        chk("lut_err",   32'(bus.core_err), 0);
        tick();

        // Core 1 with an id that is neither a channel nor the LUT.
        req(1, 8'h07); tick(); quiet();
        chk("badid_ready", 32'(bus.core_ready), 32'h02);
        chk("badid_err",   32'(bus.core_err), 32'h02);
        chk("badid_data",  dat(1), 0);
        tick();
        chk("badid_clear", 32'(bus.core_ready | bus.core_err), 0);

        // Strobe in the same cycle as the request.
        req(3, 8'h04); bus.meas_valid = 5'b10000; bus.meas = 5'b10000;
        tick(); quiet();
        chk("same_ready", 32'(bus.core_ready), 32'h08);
        chk("same_data",  dat(3), 1);
        tick();
        bus.meas = '0;

        // Timeout with no strobe: 16 wait cycles then error completion.
        req(4, 8'h01); tick(); quiet();
        repeat (15) tick();
        chk("tmo_early", 32'(bus.core_ready), 0);
        tick();
        chk("tmo_ready", 32'(bus.core_ready), 32'h10);
        chk("tmo_err",   32'(bus.core_err), 32'h10);
        chk("tmo_data",  dat(4), 0);
        tick();

        // Strobe on the final wait cycle beats the timeout.
        req(4, 8'h01); tick(); quiet();
        repeat (15) tick();
        bus.meas_valid = 5'b00010; bus.meas = 5'b00010;
        tick(); quiet();
        chk("tmo_win_ready", 32'(bus.core_ready), 32'h10);
        chk("tmo_win_err",   32'(bus.core_err), 0);
        chk("tmo_win_data",  dat(4), 1);
        tick();

        // Two cores on the same channel complete together.
        req(0, 8'h02); req(3, 8'h02); tick(); quiet();
        chk("multi_wait", 32'(bus.core_ready), 0);
        tick();
        bus.meas_valid = 5'b00100; bus.meas = 5'b00100;
        tick(); quiet();
        chk("multi_ready", 32'(bus.core_ready), 32'h09);
        chk("multi_data0", dat(0), 1);
        chk("multi_data3", dat(3), 1);
        tick();
        bus.meas = '0;

        // Enable while busy is ignored; the original request completes.
        req(1, 8'h03); tick(); quiet();
        req(1, 8'h07); tick(); quiet();
        chk("busy_ignore", 32'(bus.core_ready), 0);
        bus.meas_valid = 5'b01000;
        tick(); quiet();
        chk("busy_ready", 32'(bus.core_ready), 32'h02);
        chk("busy_err",   32'(bus.core_err), 0);
        tick();

        // Reset mid-wait drops the request silently.
        req(0, 8'h03); tick(); quiet();
        reset = 1'b1;
        #2;
        chk("rstmid_ready", 32'(bus.core_ready), 0);
        chk("rstmid_data",  32'(|bus.core_data), 0);
        #1 reset = 1'b0;
        bus.meas_valid = 5'b01000; bus.meas = 5'b01000;
        tick(); quiet();
        chk("rstmid_drop", 32'(bus.core_ready), 0);
        bus.meas = '0;
        req(0, 8'h03); tick(); quiet();
`ifdef CORE_MEAS_STICKY_EN
        chk("sticky_ready", 32'(bus.core_ready), 32'h01);
        chk("sticky_data",  dat(0), 1);
`else
        chk("nosticky_wait", 32'(bus.core_ready), 0);
        bus.meas_valid = 5'b01000; bus.meas = 5'b01000;
        tick(); quiet();
        chk("nosticky_ready", 32'(bus.core_ready), 32'h01);
        chk("nosticky_data",  dat(0), 1);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
